// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C master line engine
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } i2c_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STOP   = 3'd2,
        ST_DATA   = 3'd3,
        ST_ACKBIT = 3'd4
    } i2c_state_e;

    typedef logic [1:0] i2c_phase_t;

    localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - quarter-bit divider with restart and clock-stretch hold
module i2c_tick_gen #(
    parameter int DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic restart_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..DIV-1 while running; park at DIV-1 while the hold (stretch) input is set
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (restart_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            if (!hold_i) begin
                tick_o = 1'b1;
                cnt_d  = '0;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Divider state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_engine.sv
// rtl/i2c_master_engine.sv - byte-level I2C master line engine (START/STOP/WRITE/READ)
module i2c_master_engine #(
    parameter int DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [7:0] wdata_i,
    input  logic       ack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rdata_o,
    output logic       ack_rx_o,
    output logic       busy_o,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o
);
    import i2c_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    i2c_state_e state_q, state_d;
    i2c_phase_t phase_q, phase_d;
    i2c_cmd_e   cmd_q, cmd_d;
    logic       ack_q, ack_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_rx_q, ack_rx_d;

    logic accept;
    logic tick;
    logic enter;
    logic stretch_hold;

    assign cmd_ready_o  = (state_q == ST_IDLE) && !rsp_valid_q;
    assign accept       = cmd_valid_i && cmd_ready_o;
    assign busy_o       = (state_q != ST_IDLE);
    assign stretch_hold = (phase_q == 2'd1) && !scl_i;

    assign rsp_valid_o = rsp_valid_q;
    assign rdata_o     = rdata_q;
    assign ack_rx_o    = ack_rx_q;
    assign scl_oe_o    = scl_oe_q;
    assign sda_oe_o    = sda_oe_q;

    i2c_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .run_i     (busy_o),
        .restart_i (accept),
        .hold_i    (stretch_hold),
        .tick_o    (tick)
    );

    // Next-state logic: phase sequencing, bit shifting, and line levels applied on phase entry
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cmd_d       = cmd_q;
        ack_d       = ack_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        ack_rx_d    = ack_rx_q;
        enter       = 1'b0;

        if (accept) begin
            cmd_d     = i2c_cmd_e'(cmd_i);
            ack_d     = ack_i;
            shreg_d   = wdata_i;
            bit_cnt_d = 3'd0;
            phase_d   = 2'd0;
            enter     = 1'b1;
            case (i2c_cmd_e'(cmd_i))
                CMD_START: state_d = ST_START;
                CMD_STOP:  state_d = ST_STOP;
                default:   state_d = ST_DATA;
            endcase
        end else if (tick) begin
            // SDA is sampled on the last clock of the SCL-high phase
            if (phase_q == 2'd2) begin
                if (state_q == ST_DATA) begin
                    shreg_d = {shreg_q[6:0], sda_i};
                end
                if (state_q == ST_ACKBIT && cmd_q == CMD_WRITE) begin
                    ack_rx_d = !sda_i;
                end
            end

            if (phase_q == 2'd3) begin
                phase_d = 2'd0;
                case (state_q)
                    ST_DATA: begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_ACKBIT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                        enter = 1'b1;
                    end
                    ST_ACKBIT: begin
                        if (cmd_q == CMD_READ) begin
                            rdata_d = shreg_q;
                        end
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                    end
                    default: begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                    end
                endcase
            end else begin
                phase_d = phase_q + 2'd1;
                enter   = 1'b1;
            end
        end

        // Open-drain levels change only at the start of a phase; anything not listed holds
        if (enter) begin
            case (state_d)
                ST_START: begin
                    case (phase_d)
                        2'd0:    sda_oe_d = 1'b0;
                        2'd1:    scl_oe_d = 1'b0;
                        2'd2:    sda_oe_d = 1'b1;
                        default: scl_oe_d = 1'b1;
                    endcase
                end
                ST_STOP: begin
                    case (phase_d)
                        2'd0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = 1'b1;
                        end
                        2'd1:    scl_oe_d = 1'b0;
                        2'd2:    sda_oe_d = 1'b0;
                        default: scl_oe_d = scl_oe_q;
                    endcase
                end
                ST_DATA: begin
                    case (phase_d)
                        2'd0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = (cmd_d == CMD_WRITE) ? !shreg_d[7] : 1'b0;
                        end
                        2'd1:    scl_oe_d = 1'b0;
                        2'd2:    scl_oe_d = 1'b0;
                        default: scl_oe_d = 1'b1;
                    endcase
                end
                ST_ACKBIT: begin
                    case (phase_d)
                        2'd0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = (cmd_d == CMD_READ) ? ack_d : 1'b0;
                        end
                        2'd1:    scl_oe_d = 1'b0;
                        2'd2:    scl_oe_d = 1'b0;
                        default: scl_oe_d = 1'b1;
                    endcase
                end
                default: begin
                    scl_oe_d = scl_oe_q;
                    sda_oe_d = sda_oe_q;
                end
            endcase
        end
    end

    // State, datapath and line-driver registers; reset releases both lines immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd0;
            cmd_q       <= CMD_START;
            ack_q       <= 1'b0;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            ack_rx_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cmd_q       <= cmd_d;
            ack_q       <= ack_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            ack_rx_q    <= ack_rx_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_engine.sv
// tb/tb_i2c_master_engine.sv - scoreboard bench for the I2C master line engine with slave BFM
module tb_i2c_master_engine;

    localparam int DIV = 4;
    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_STOP  = 2'd1;
    localparam logic [1:0] C_WRITE = 2'd2;
    localparam logic [1:0] C_READ  = 2'd3;
    localparam int LAT_SS   = 4 * DIV + 1;
    localparam int LAT_BYTE = 36 * DIV + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] wdata = 8'h00;
    logic       ack = 1'b0;
    logic       cmd_ready_o, rsp_valid_o, ack_rx_o, busy_o, scl_oe_o, sda_oe_o;
    logic [7:0] rdata_o;
    logic       bfm_scl_low = 1'b0;
    logic       bfm_sda_low = 1'b0;
    wire        scl_line = !(scl_oe_o || bfm_scl_low);
    wire        sda_line = !(sda_oe_o || bfm_sda_low);

    i2c_master_engine #(.DIV(DIV)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_i       (cmd),
        .wdata_i     (wdata),
        .ack_i       (ack),
        .rsp_valid_o (rsp_valid_o),
        .rdata_o     (rdata_o),
        .ack_rx_o    (ack_rx_o),
        .busy_o      (busy_o),
        .scl_i       (scl_line),
        .sda_i       (sda_line),
        .scl_oe_o    (scl_oe_o),
        .sda_oe_o    (sda_oe_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        string      name;
        int         acc;
        int         lat;
        logic       chk_rd;
        logic [7:0] rd;
        logic       chk_ack;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Response monitor: pop the scoreboard on each rsp pulse and compare
    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: rsp_valid_o=1 at cycle %0d, no response expected", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                if (mon_e.chk_rd)  check({mon_e.name, "_rdata"}, 32'(rdata_o), 32'(mon_e.rd));
                if (mon_e.chk_ack) check({mon_e.name, "_ack_rx"}, 32'(ack_rx_o), 32'(mon_e.ack));
            end
            n_rsp++;
        end
    end

    // Slave BFM configuration (written by stimulus) and state (owned by the BFM)
    int         cfg_mode = 0;       // 0 = passive/NACK, 1 = ACK writes, 2 = supply read byte
    logic [7:0] cfg_rd = 8'h00;
    logic       cfg_stretch = 1'b0;
    int         mode = 0;
    logic [7:0] rd_byte = 8'h00;
    logic       arm = 1'b0;
    int         edge_cnt = 0;
    int         stretch_cnt = 0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0;
    logic       b_scl, b_sda;
    logic [7:0] cap = 8'h00;
    logic       oe_at_ack = 1'b0;
    int         start_cnt = 0, stop_cnt = 0;

    // Slave BFM: counts SCL rises, captures SDA, ACKs/drives read data, stretches, spots START/STOP
    always @(negedge clk) begin
        if (rst_i) begin
            bfm_scl_low = 1'b0;
            bfm_sda_low = 1'b0;
            edge_cnt    = 0;
            stretch_cnt = 0;
            arm         = 1'b0;
            prev_busy   = 1'b0;
            prev_scl    = 1'b1;
            prev_sda    = 1'b1;
        end else begin
            if (busy_o && !prev_busy) begin
                mode      = cfg_mode;
                rd_byte   = cfg_rd;
                arm       = cfg_stretch;
                edge_cnt  = 0;
                cap       = 8'h00;
                oe_at_ack = 1'b0;
            end
            prev_busy = busy_o;

            if (stretch_cnt > 0) begin
                stretch_cnt--;
                if (stretch_cnt == 0) bfm_scl_low = 1'b0;
            end else if (arm && !scl_oe_o && !prev_scl && edge_cnt == 3) begin
                bfm_scl_low = 1'b1;
                stretch_cnt = DIV + 19;
                arm         = 1'b0;
            end

            b_scl = !(scl_oe_o || bfm_scl_low);
            b_sda = !(sda_oe_o || bfm_sda_low);
            if (b_scl && !prev_scl) begin
                edge_cnt++;
                if (edge_cnt <= 8) cap = {cap[6:0], b_sda};
                if (edge_cnt == 9) oe_at_ack = sda_oe_o;
            end
            if (b_scl && prev_scl) begin
                if (prev_sda && !b_sda) start_cnt++;
                if (!prev_sda && b_sda) stop_cnt++;
            end
            if (!b_scl) begin
                case (mode)
                    1:       bfm_sda_low = (edge_cnt == 8);
                    2:       bfm_sda_low = (edge_cnt < 8) ? !rd_byte[3'(7 - edge_cnt)] : 1'b0;
                    default: bfm_sda_low = 1'b0;
                endcase
            end
            b_sda    = !(sda_oe_o || bfm_sda_low);
            prev_scl = b_scl;
            prev_sda = b_sda;
        end
    end

    task automatic send(input logic [1:0] c, input logic [7:0] wd, input logic a, input string nm,
                        input int lat, input logic chk_rd, input logic [7:0] rd,
                        input logic chk_ack, input logic ak);
        exp_t e;
        int   n = 0;
        @(posedge clk); #2;
        while (!cmd_ready_o && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check({nm, "_ready_before"}, 32'(cmd_ready_o), 32'd1);
        e.name = nm; e.acc = cyc; e.lat = lat;
        e.chk_rd = chk_rd; e.rd = rd; e.chk_ack = chk_ack; e.ack = ak;
        exp_q.push_back(e);
        cmd = c; wdata = wd; ack = a; cmd_valid = 1'b1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, output logic ready_seen, output logic oe_seen);
        int n0 = n_rsp;
        int k  = 0;
        ready_seen = 1'b0;
        oe_seen    = 1'b0;
        while (n_rsp == n0 && k < 1000) begin
            @(negedge clk); #1;
            ready_seen |= cmd_ready_o;
            oe_seen    |= sda_oe_o;
            k++;
        end
        check({nm, "_completed"}, 32'(n_rsp != n0), 32'd1);
    endtask

    logic rdy, oe;
    int   n0, k;

    initial begin
        #1;
        check("rst_scl_oe", 32'(scl_oe_o), 32'd0);
        check("rst_sda_oe", 32'(sda_oe_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
        #1 check("ready_after_rst", 32'(cmd_ready_o), 32'd1);
        check("rst_rdata", 32'(rdata_o), 32'd0);
        check("rst_ack_rx", 32'(ack_rx_o), 32'd0);

        // START with an ignored command offered while busy, then STOP
        send(C_START, 8'h00, 1'b0, "start1", LAT_SS, 1'b0, 8'h00, 1'b0, 1'b0);
        cmd = C_STOP; cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2 cmd_valid = 1'b0;
        wait_rsp("start1", rdy, oe);
        check("start1_ready_low", 32'(rdy), 32'd0);
        send(C_STOP, 8'h00, 1'b0, "stop1", LAT_SS, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_rsp("stop1", rdy, oe);
        check("stop1_ready_low", 32'(rdy), 32'd0);
        check("start_cond_count1", 32'(start_cnt), 32'd1);
        check("stop_cond_count1", 32'(stop_cnt), 32'd1);

        // WRITE 0xA5 with slave ACK
        cfg_mode = 1;
        send(C_WRITE, 8'hA5, 1'b0, "wr_a5", LAT_BYTE, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_rsp("wr_a5", rdy, oe);
        check("wr_a5_bus_bits", 32'(cap), 32'hA5);
        check("wr_a5_oe_ack", 32'(oe_at_ack), 32'd0);

        // WRITE 0x00 with slave NACK
        cfg_mode = 0;
        send(C_WRITE, 8'h00, 1'b0, "wr_00", LAT_BYTE, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_rsp("wr_00", rdy, oe);
        check("wr_00_bus_bits", 32'(cap), 32'h00);
        check("wr_00_oe_ack", 32'(oe_at_ack), 32'd0);

        // READ 0x3C, master NACKs
        cfg_mode = 2; cfg_rd = 8'h3C;
        send(C_READ, 8'hFF, 1'b0, "rd_3c", LAT_BYTE, 1'b1, 8'h3C, 1'b0, 1'b0);
        wait_rsp("rd_3c", rdy, oe);
        check("rd_3c_sda_oe_never", 32'(oe), 32'd0);

        // READ 0x96, master ACKs
        cfg_rd = 8'h96;
        send(C_READ, 8'h00, 1'b1, "rd_96", LAT_BYTE, 1'b1, 8'h96, 1'b0, 1'b0);
        wait_rsp("rd_96", rdy, oe);
        check("rd_96_oe_ack", 32'(oe_at_ack), 32'd1);

        // WRITE 0x55 with the slave stretching SCL in bit 3; rdata must still hold 0x96
        cfg_mode = 1; cfg_stretch = 1'b1;
        send(C_WRITE, 8'h55, 1'b0, "wr_55_stretch", LAT_BYTE + 20, 1'b1, 8'h96, 1'b1, 1'b1);
        wait_rsp("wr_55_stretch", rdy, oe);
        cfg_stretch = 1'b0;
        check("wr_55_bus_bits", 32'(cap), 32'h55);

        // Reset in the middle of a WRITE
        cfg_mode = 0;
        send(C_WRITE, 8'h00, 1'b0, "wr_rst", LAT_BYTE, 1'b0, 8'h00, 1'b0, 1'b0);
        k = 0;
        while (!(edge_cnt >= 5 && scl_oe_o) && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        check("pre_rst_lines_driven", 32'({scl_oe_o, sda_oe_o}), 32'd3);
        #1 rst_i = 1'b1;
        #1 check("async_rst_scl_oe", 32'(scl_oe_o), 32'd0);
        check("async_rst_sda_oe", 32'(sda_oe_o), 32'd0);
        exp_q.delete();
        n0 = n_rsp;
        repeat (2) @(posedge clk);
        #2 rst_i = 1'b0;
        #1 check("ready_after_mid_rst", 32'(cmd_ready_o), 32'd1);
        check("busy_after_mid_rst", 32'(busy_o), 32'd0);
        check("rdata_after_mid_rst", 32'(rdata_o), 32'd0);
        repeat (40) @(negedge clk);
        check("no_rsp_after_rst", 32'(n_rsp), 32'(n0));

        send(C_START, 8'h00, 1'b0, "start2", LAT_SS, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_rsp("start2", rdy, oe);
        send(C_STOP, 8'h00, 1'b0, "stop2", LAT_SS, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_rsp("stop2", rdy, oe);
        check("start_cond_count2", 32'(start_cnt), 32'd2);
        check("stop_cond_count2", 32'(stop_cnt), 32'd2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_engine.md
Name: i2c_master_engine

Overview:
- Byte-level I2C master line engine; sits directly downstream of the memory-mapped i2c register block, which converts CPU writes into commands.
- Executes START / STOP / WRITE-byte / READ-byte commands on open-drain SCL/SDA and returns one response per command.
- Supports slave clock stretching. Does no protocol sequencing or address logic; the register block owns that.

Parameters:
- DIV, 16, system clocks per quarter SCL bit-period; legal range 2..65535. SCL = f_clk / (4*DIV).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  engine idle, accepts command this cycle
- cmd_i  in  2  i2c_cmd_e: START=0, STOP=1, WRITE=2, READ=3
- wdata_i  in  8  byte for WRITE, sampled at accept
- ack_i  in  1  READ only: 1 = master drives ACK after the byte, 0 = NACK; sampled at accept
- rsp_valid_o  out  1  one-cycle pulse, command complete
- rdata_o  out  8  byte received by the last READ; held until next READ completes
- ack_rx_o  out  1  WRITE only: 1 = slave ACKed (SDA low in 9th bit); held
- busy_o  out  1  command in progress
- scl_i  in  1  synchronised SCL pin level
- sda_i  in  1  synchronised SDA pin level
- scl_oe_o  out  1  1 = pull SCL low
- sda_oe_o  out  1  1 = pull SDA low

Behaviour:
- Reset values (async, immediate): scl_oe_o=0, sda_oe_o=0, rsp_valid_o=0, rdata_o=0, ack_rx_o=0, busy_o=0. Reset mid-command releases both lines in the same cycle with no STOP generated.
- cmd_ready_o = (state==IDLE) && !rsp_valid_o. It is 1 in the first cycle after reset deasserts.
- Accept on cmd_valid_i && cmd_ready_o. Latch cmd, wdata and ack, then go to busy the next cycle. cmd_valid_i while not ready is ignored.
- Tick: a counter 0..DIV-1 pulses once per DIV clocks while busy. It restarts at 0 on accept. Each phase lasts exactly one tick.
- FSM states: IDLE, START, STOP, DATA, ACKBIT. Every state cycles phases p0..p3.
- START (also a repeated start):
  - p0: release SDA.
  - p1: release SCL.
  - p2: SDA low while SCL high.
  - p3: SCL low.
  - Then response.
- STOP:
  - p0: SCL low, SDA low.
  - p1: release SCL.
  - p2: release SDA (SDA rises while SCL high).
  - p3: hold.
  - Then response.
- DATA (8 bits, MSB first), then ACKBIT:
  - p0: SCL low; set SDA. WRITE drives the data bit; READ releases SDA.
  - p1: release SCL.
  - p2: SCL high. Sample sda_i on the last clock of p2.
  - p3: SCL low.
- ACKBIT drives SDA as follows:
  - WRITE: released; ack_rx_o <= !sda_i.
  - READ: low if latched ack=1, else released.
- Clock stretching: the p1 tick does not advance while scl_i==0. The divider holds at DIV-1 until scl_i==1, then p2 starts next cycle. No timeout.
- Completion: rsp_valid_o pulses on the clock after the final p3 tick; the FSM returns to IDLE on the same edge. rdata_o and ack_rx_o are valid in the pulse cycle.
- Latency, accept to rsp_valid_o, with no stretching:
  - START/STOP: 4*DIV+1 cycles.
  - WRITE/READ: 36*DIV+1 cycles.
- WRITE/READ issued without a prior START executes anyway; no bus-state check.
- SDA changes only while SCL is low, except in START p2 and STOP p2.
- DIV=2 is the minimum; the counter width is $clog2(DIV).

Decomposition:
- Package i2c_pkg:
  - typedef enum logic [1:0] i2c_cmd_e.
  - typedef enum i2c_state_e.
  - typedef logic [1:0] i2c_phase_t.
  - localparam BITS_PER_BYTE=8.
- Sub-module i2c_tick_gen: DIV counter with restart and stretch-hold inputs, tick output.

Test Plan (DIV=4, slave BFM on the open-drain pins):
- START then STOP from idle -> SDA falls while SCL=1, later rises while SCL=1. Each rsp_valid_o arrives 17 cycles after accept. cmd_ready_o is low throughout.
- WRITE 0xA5, BFM ACKs -> SDA at SCL rising edges = 1,0,1,0,0,1,0,1. ack_rx_o=1. rsp_valid_o 145 cycles after accept.
- WRITE 0x00, BFM NACKs -> ack_rx_o=0 and sda_oe_o=0 during the 9th bit.
- READ with ack_i=0, BFM drives 0x3C -> rdata_o=0x3C, sda_oe_o=0 for the whole command. Repeat with ack_i=1 -> sda_oe_o=1 during the 9th SCL high.
- BFM holds SCL low 20 extra cycles in bit 3 of WRITE 0x55 -> completion delayed by exactly 20 cycles; data still correct.
- Assert rst_i mid-WRITE (bit 5) -> scl_oe_o/sda_oe_o drop to 0 asynchronously and no rsp_valid_o. cmd_ready_o=1 in the first cycle after release; a following START completes normally.
